div_sequencer: RTL and testbench

- Multi-cycle sequencer for the RV32M divide/remainder instructions DIV, DIVU, REM and REMU.
- Runs a restoring shift-subtract loop: one 33-bit trial subtraction per cycle through a single shared adder path, then sign correction.
- Sits beside the ALU in the execute stage. It stalls the pipeline through `busy` and returns the result with a one-cycle `done` pulse.

---
 rtl/div_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_div_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle RV32M DIV/DIVU/REM/REMU engine.
// Restoring shift-subtract, one trial subtraction per cycle, then sign fix-up.
module div_sequencer #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            dz
);

    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CALC = 3'd1,
        S_SIGN = 3'd2,
        S_FAST = 3'd3,
        S_DONE = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  dsr_q, dsr_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic             rem_sel_q, rem_sel_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;

    logic             accept;
    logic             in_signed;
    logic             a_neg;
    logic             b_neg;
    logic             special;
    logic [XLEN-1:0]  abs_a;
    logic [XLEN-1:0]  abs_b;
    logic [XLEN-1:0]  rem_sh;
    logic [XLEN-1:0]  quo_sh;
    logic [XLEN:0]    trial;
    logic [XLEN-1:0]  quo_fix;
    logic [XLEN-1:0]  rem_fix;

    // Operand conditioning at capture time and the per-cycle shift/trial-subtract path
    always_comb begin
        in_signed = ~op[0];
        a_neg     = in_signed & dividend[XLEN-1];
        b_neg     = in_signed & divisor[XLEN-1];
        abs_a     = a_neg ? -dividend : dividend;
        abs_b     = b_neg ? -divisor : divisor;
        special   = (divisor == '0) ||
                    (in_signed && (dividend == MIN_NEG) && (divisor == ALL_ONES));
        accept    = (state_q == S_IDLE) && start && !kill && !done_q;
        rem_sh    = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
        quo_sh    = {quo_q[XLEN-2:0], 1'b0};
        trial     = {1'b0, rem_sh} - {1'b0, dsr_q};
        quo_fix   = neg_quo_q ? -quo_q : quo_q;
        rem_fix   = neg_rem_q ? -rem_q : rem_q;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dsr_d     = dsr_q;
        rem_sel_d = rem_sel_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        dz_d      = dz_q;
        done_d    = (state_q == S_DONE);
        busy_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    rem_sel_d = op[1];
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    rem_d     = '0;
                    dsr_d     = abs_b;
                    dz_d      = 1'b0;
                    // Special cases keep the raw dividend: REM-by-zero returns it verbatim
                    quo_d     = special ? dividend : abs_a;
                    if (special) begin
                        state_d = S_FAST;
                    end else begin
                        state_d = S_CALC;
                        cnt_d   = CNT_W'(XLEN);
                    end
                end
            end
            S_CALC: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else begin
                    quo_d = quo_sh;
                    rem_d = rem_sh;
                    if (!trial[XLEN]) begin
                        rem_d    = trial[XLEN-1:0];
                        quo_d[0] = 1'b1;
                    end
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_SIGN;
                    end
                end
            end
            S_SIGN: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else begin
                    result_d = rem_sel_q ? rem_fix : quo_fix;
                    state_d  = S_DONE;
                end
            end
            S_FAST: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else begin
                    // Zero divisor leaves dsr at zero; otherwise this is signed overflow
                    if (dsr_q == '0) begin
                        result_d = rem_sel_q ? quo_q : ALL_ONES;
                        dz_d     = 1'b1;
                    end else begin
                        result_d = rem_sel_q ? '0 : MIN_NEG;
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dsr_q     <= '0;
            rem_sel_q <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dsr_q     <= dsr_d;
            rem_sel_q <= rem_sel_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign dz     = dz_q;

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed vectors for div_sequencer, checked against an
// arithmetic/latency model every cycle and against hand-computed literals.
module tb_div_sequencer;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        dz;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // model state
    int          m_left = 0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] m_result = '0;
    logic        m_dz = 1'b0;
    logic [31:0] p_result = '0;
    logic        p_dz = 1'b0;

    div_sequencer #(.XLEN(32), .CNT_W(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .kill     (kill),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .dz       (dz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // RV32M arithmetic plus the documented 2/34-cycle latencies
    function automatic void model_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] r, output logic d, output int lat);
        logic ovf;
        ovf = !o[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        d   = (b == 32'd0);
        lat = (d || ovf) ? 2 : 34;
        r   = '0;
        case (o)
            OP_DIV:  r = d ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b)));
            OP_DIVU: r = d ? 32'hFFFF_FFFF : a / b;
            OP_REM:  r = d ? a : (ovf ? 32'd0 : 32'($signed(a) % $signed(b)));
            default: r = d ? a : a % b;
        endcase
    endfunction

    // Model: on each rising edge, apply reset, abort, countdown or accept
    initial forever begin
        logic acc;
        int   lat;
        @(posedge clk);
        if (rst) begin
            m_left = 0; m_done = 1'b0; m_result = '0; m_dz = 1'b0;
        end else begin
            acc    = (m_left == 0) && !m_done && start && !kill;
            m_done = 1'b0;
            if (m_left != 0) begin
                if (kill && m_left > 1) begin
                    m_left = 0;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_done   = 1'b1;
                        m_result = p_result;
                        m_dz     = p_dz;
                    end
                end
            end else if (acc) begin
                model_op(op, dividend, divisor, p_result, p_dz, lat);
                m_left = lat;
                m_dz   = 1'b0;
            end
        end
        m_busy = (m_left != 0);
    end

    // Compare DUT against model on every falling edge
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("model busy", 32'(busy), 32'(m_busy));
            chk("model done", 32'(done), 32'(m_done));
            if (m_done || !m_busy) begin
                chk("model result", result, m_result);
                chk("model dz", 32'(dz), 32'(m_dz));
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        start = 1'b1; op = o; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0; op = 2'($urandom); dividend = $urandom; divisor = $urandom;
    endtask

    // n0 = edges already elapsed since the accept edge
    task automatic wait_done(input int n0, input int lat, input string tag);
        int n;
        bit got;
        n = n0; got = 1'b0;
        while (!got && n < 100) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (done) got = 1'b1;
        end
        chk({tag, " latency"}, 32'(n), 32'(lat));
    endtask

    task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic d, input int lat, input string tag);
        issue(o, a, b);
        @(negedge clk);
        chk({tag, " busy rise"}, 32'(busy), 32'd1);
        wait_done(0, lat, tag);
        chk({tag, " result"}, result, res);
        chk({tag, " dz"}, 32'(dz), 32'(d));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset dz", 32'(dz), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run(OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 34, "divu 100/7");
        run(OP_REMU, 32'd100, 32'd7, 32'd2, 1'b0, 34, "remu 100/7");
        run(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 34, "div -7/2");
        run(OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 34, "rem -7/2");
        run(OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 34, "div 7/-2");
        run(OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0, 34, "rem 7/-2");
        run(OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 2, "div 5/0");
        run(OP_REMU, 32'd5, 32'd0, 32'd5, 1'b1, 2, "remu 5/0");
        run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 2, "div ovf");
        run(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 2, "rem ovf");
        run(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 34, "divu ovf-operands");
        run(OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b0, 34, "div -100/7");
        run(OP_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 1'b0, 34, "rem -100/7");
        run(OP_DIV, 32'h8000_0000, 32'd2, 32'hC000_0000, 1'b0, 34, "div min/2");
        run(OP_REM, 32'h8000_0000, 32'd3, 32'hFFFF_FFFE, 1'b0, 34, "rem min/3");
        run(OP_REMU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 1'b0, 34, "remu big");
        run(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 34, "divu max/1");

        // kill mid-CALC: no done, result unchanged, then an immediate new op
        run(OP_DIVU, 32'd0, 32'd9, 32'd0, 1'b0, 34, "divu 0/9");
        issue(OP_DIVU, 32'd1000, 32'd10);
        repeat (8) @(posedge clk);
        #1 kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        @(negedge clk);
        chk("kill busy", 32'(busy), 32'd0);
        chk("kill done", 32'(done), 32'd0);
        chk("kill result", result, 32'd0);
        run(OP_DIVU, 32'd9, 32'd3, 32'd3, 1'b0, 34, "divu 9/3");

        // start re-pulsed while busy is ignored
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (4) @(posedge clk);
        #1 start = 1'b1; op = OP_DIV; dividend = 32'd50; divisor = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(5, 34, "repulse");
        chk("repulse result", result, 32'd14);

        // start during the done cycle is ignored
        start = 1'b1; op = OP_DIVU; dividend = 32'd8; divisor = 32'd2;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("done-cycle start busy", 32'(busy), 32'd0);
        chk("done-cycle start result", result, 32'd14);
        repeat (3) @(negedge clk);

        // synchronous reset mid-CALC
        issue(OP_DIVU, 32'd1000, 32'd7);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst result", result, 32'd0);
        chk("rst dz", 32'(dz), 32'd0);
        repeat (40) @(negedge clk);

        run(OP_REM, 32'd7, 32'd0, 32'd7, 1'b1, 2, "rem 7/0");
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
